capp_array: RTL
===============

CAPP_ARRAY -- requirements
Module: capp_array

Interface
REQ-001 Parameter WIDTH, default 32: bits per stored word, comparand and mask.
REQ-002 Parameter DEPTH, default 16: number of stored words; AW = clog2(DEPTH) is derived, not overridable.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  3  opcode per REQ-012.
REQ-008 cmd_data  input  WIDTH  operand for load/write ops.
REQ-009 cmd_addr  input  AW  word index for WRITE_ADDR.
REQ-010 rsp_valid  output  1 | rsp_hit  output  1 | rsp_data  output  WIDTH | rsp_addr  output  AW  READ_FIRST result.
REQ-011 tags  output  DEPTH  responder tag per word | any_match  output  1  OR of tags.

Function
REQ-012 Opcodes SHALL be: 0 NOP, 1 LOAD_CMP, 2 LOAD_MASK, 3 WRITE_ADDR, 4 SEARCH, 5 MULTI_WRITE, 6 READ_FIRST, 7 SET_TAGS.
REQ-013 A command SHALL be accepted only on a cycle with cmd_valid && cmd_ready; otherwise inputs are ignored.
REQ-014 States SHALL be IDLE, SEARCH, WRITE, RESOLVE; cmd_ready = 1 only in IDLE.
REQ-015 NOP, LOAD_CMP, LOAD_MASK, WRITE_ADDR, SET_TAGS SHALL complete at the accept edge, remain in IDLE and keep cmd_ready high.
REQ-016 LOAD_CMP/LOAD_MASK SHALL load cmd_data into comparand/mask; WRITE_ADDR SHALL write cmd_data to word cmd_addr; cmd_addr >= DEPTH SHALL be a no-op; SET_TAGS SHALL set all tags to 1.
REQ-017 Bit j of word i SHALL match when mask[j] = 0 or word[i][j] == comparand[j]; all-zero mask matches every word.
REQ-018 SEARCH: accepted at edge N -> state SEARCH during cycle N+1; at edge N+1 tags <= match vector, any_match updates, state IDLE; cmd_ready low for exactly one cycle.
REQ-019 MULTI_WRITE: accepted at edge N -> state WRITE; at edge N+1 every tagged word SHALL become (word & ~mask) | (comparand & mask); tags unchanged; return to IDLE.
REQ-020 READ_FIRST: accepted at edge N -> state RESOLVE; at edge N+1 rsp_valid = 1 for exactly one cycle; lowest-index tagged word i gives rsp_hit = 1, rsp_data = word[i], rsp_addr = i, and tag i cleared.
REQ-021 READ_FIRST with no tags set SHALL give rsp_valid = 1, rsp_hit = 0, rsp_data = 0, rsp_addr = 0.
REQ-022 Outputs rsp_hit/rsp_data/rsp_addr SHALL hold their last value when rsp_valid = 0.
REQ-023 Comparand/mask loaded at the same edge a SEARCH is accepted is impossible (one command per accept); a SEARCH SHALL use register values present in the SEARCH cycle.

Reset
REQ-024 RST high SHALL immediately force state IDLE, all words, comparand, mask, tags to 0, rsp_valid/rsp_hit/rsp_data/rsp_addr/any_match to 0, cmd_ready to 1 after release.
REQ-025 RST asserted during SEARCH/WRITE/RESOLVE SHALL abort the op with no rsp_valid pulse and no word write.

Configuration
REQ-026 Macro CAPP_RESP_COUNT_EN defined: extra output resp_count (output, AW+1 bits) SHALL equal popcount of tags, registered, updated same edge as tags, reset 0.
REQ-027 Macro CAPP_RESP_COUNT_EN undefined: port resp_count and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 WIDTH=8, DEPTH=4; WRITE_ADDR words 0x12,0x34,0x1F,0x12; LOAD_CMP 0x12, LOAD_MASK 0xFF, SEARCH -> tags = 4'b1001, any_match = 1, resp_count = 2.
REQ-029 Then LOAD_MASK 0x0F, LOAD_CMP 0x02, SEARCH -> tags = 4'b1001; LOAD_MASK 0x00 SEARCH -> tags = 4'b1111.
REQ-030 Tags 4'b1001, LOAD_CMP 0xA0, LOAD_MASK 0xF0, MULTI_WRITE -> words 0xA2,0x34,0x1F,0xA2; cmd_ready low one cycle.
REQ-031 Tags 4'b1001; READ_FIRST x3 -> (hit, addr 0), (hit, addr 3), (rsp_hit 0, data 0); tags end 4'b0000.
REQ-032 RST pulsed in the cycle after READ_FIRST accept -> no rsp_valid, all words 0, tags 0, cmd_ready 1 after release.

Source files
------------

// File: rtl/capp_array.sv
// capp_array: content-addressable parallel processor word array.
// Masked parallel search, tagged multi-write and priority read-out.
//
// Ports:
//   CLK, RST         clock, asynchronous active-high reset
//   cmd_valid/ready  command handshake (ready only while idle)
//   cmd_op           0 NOP, 1 LOAD_CMP, 2 LOAD_MASK, 3 WRITE_ADDR,
//                    4 SEARCH, 5 MULTI_WRITE, 6 READ_FIRST, 7 SET_TAGS
//   cmd_data         operand for load/write ops
//   cmd_addr         word index for WRITE_ADDR
//   rsp_valid        one-cycle READ_FIRST result strobe
//   rsp_hit/data/addr READ_FIRST result, held while rsp_valid is low
//   tags             responder tag per word
//   any_match        OR of all tags
//   resp_count       popcount of tags (only with CAPP_RESP_COUNT_EN)
//
// Optional feature macro: CAPP_RESP_COUNT_EN adds the resp_count port.
module capp_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [AW-1:0]    cmd_addr,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AW-1:0]    rsp_addr,
  output logic [DEPTH-1:0] tags,
  output logic             any_match
`ifdef CAPP_RESP_COUNT_EN
  ,
  output logic [AW:0]      resp_count
`endif
);

  typedef enum logic [2:0] {
    OP_NOP         = 3'd0,
    OP_LOAD_CMP    = 3'd1,
    OP_LOAD_MASK   = 3'd2,
    OP_WRITE_ADDR  = 3'd3,
    OP_SEARCH      = 3'd4,
    OP_MULTI_WRITE = 3'd5,
    OP_READ_FIRST  = 3'd6,
    OP_SET_TAGS    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    WRITE   = 2'd2,
    RESOLVE = 2'd3
  } state_e;

  state_e state;
  state_e state_nxt;

  logic [WIDTH-1:0] words [DEPTH];
  logic [WIDTH-1:0] cmp;
  logic [WIDTH-1:0] mask;

  logic             accept;
  op_e              op;
  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] tags_nxt;
  logic             first_hit;
  logic [AW-1:0]    first_idx;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign any_match = |tags;

  // A masked-off bit always matches; zero mask matches every word.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = ((words[i] ^ cmp) & mask) == '0;
    end
  end

  // Lowest-index tagged word wins: scan downward so the last
  // assignment is the smallest index.
  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tags[i]) begin
        first_hit = 1'b1;
        first_idx = AW'(i);
      end
    end
  end

  always_comb begin
    tags_nxt = tags;
    if (accept && op == OP_SET_TAGS) begin
      tags_nxt = '1;
    end
    if (state == SEARCH) begin
      tags_nxt = match;
    end
    if (state == RESOLVE && first_hit) begin
      tags_nxt[first_idx] = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_SEARCH:      state_nxt = SEARCH;
            OP_MULTI_WRITE: state_nxt = WRITE;
            OP_READ_FIRST:  state_nxt = RESOLVE;
            default:        state_nxt = IDLE;
          endcase
        end
      end
      SEARCH:  state_nxt = IDLE;
      WRITE:   state_nxt = IDLE;
      RESOLVE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        words[i] <= '0;
      end
      cmp       <= '0;
      mask      <= '0;
      tags      <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
    end else begin
      tags      <= tags_nxt;
      rsp_valid <= (state == RESOLVE);
      if (accept) begin
        case (op)
          OP_LOAD_CMP:  cmp  <= cmd_data;
          OP_LOAD_MASK: mask <= cmd_data;
          OP_WRITE_ADDR: begin
            if (int'(cmd_addr) < DEPTH) begin
              words[cmd_addr] <= cmd_data;
            end
          end
          default: ;
        endcase
      end
      if (state == WRITE) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (tags[i]) begin
            words[i] <= (words[i] & ~mask) | (cmp & mask);
          end
        end
      end
      if (state == RESOLVE) begin
        rsp_hit  <= first_hit;
        rsp_data <= first_hit ? words[first_idx] : '0;
        rsp_addr <= first_hit ? first_idx : '0;
      end
    end
  end

`ifdef CAPP_RESP_COUNT_EN
  // Registered alongside tags so the count always describes them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_count <= '0;
    end else begin
      resp_count <= (AW+1)'($countones(tags_nxt));
    end
  end
`endif

endmodule
